// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_W = 8;
  localparam int REG_DAT_W      = 32;
  localparam int INS_DAT_W      = 32;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } icState_t;

endpackage

// File: rtl/icache_line_ram.sv
// Tag and data storage for the instruction cache: combinational read port,
// synchronous write port. Valid bits live in the parent so reset can clear them.
module icache_line_ram #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 22,
  parameter int DAT_W   = 32
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_wIdx,
  input  logic [TAG_W-1:0]   i_wTag,
  input  logic [DAT_W-1:0]   i_wDat,
  input  logic [INDEX_W-1:0] i_rIdx,
  output logic [TAG_W-1:0]   o_rTag,
  output logic [DAT_W-1:0]   o_rDat
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [DAT_W-1:0] r_dat [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wIdx] <= i_wTag;
      r_dat[i_wIdx] <= i_wDat;
    end
  end

  assign o_rTag = r_tag[i_rIdx];
  assign o_rDat = r_dat[i_rIdx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller. Misses issue a single word read and fill on return.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int ADDR_W  = REG_DAT_W,
  parameter int INS_W   = INS_DAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iIF_En,
  input  logic [ADDR_W-1:0] iIF_Pc,
  output logic              oIF_Rdy,
  input  logic              iClr,
  output logic              oIns_En,
  output logic [INS_W-1:0]  oIns,
  output logic              oMC_En,
  output logic [ADDR_W-1:0] oMC_Addr,
  input  logic              iMC_En,
  input  logic [INS_W-1:0]  iMC_Dat
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  icState_t            r_state;
  logic                r_drop;
  logic [LINES-1:0]    r_valid;
  logic                r_insEn;
  logic [INS_W-1:0]    r_ins;
  logic                r_mcEn;
  logic [ADDR_W-1:0]   r_mcAddr;

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [TAG_W-1:0]    w_lineTag;
  logic [INS_W-1:0]    w_lineDat;
  logic                w_hit;
  logic                w_fill;
  logic [INDEX_W-1:0]  w_fillIdx;
  logic [TAG_W-1:0]    w_fillTag;

  assign w_index   = iIF_Pc[INDEX_W+1:2];
  assign w_tag     = iIF_Pc[ADDR_W-1:INDEX_W+2];
  assign w_hit     = r_valid[w_index] && (w_lineTag == w_tag);
  assign oIF_Rdy   = (r_state == IC_IDLE);

  // The fill address comes from the held request so a flushed miss still fills.
  assign w_fillIdx = r_mcAddr[INDEX_W+1:2];
  assign w_fillTag = r_mcAddr[ADDR_W-1:INDEX_W+2];
  assign w_fill    = !rst && en && (r_state == IC_MISS) && iMC_En;

  icache_line_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DAT_W   (INS_W)
  ) u_lineRam (
    .clk    (clk),
    .i_we   (w_fill),
    .i_wIdx (w_fillIdx),
    .i_wTag (w_fillTag),
    .i_wDat (iMC_Dat),
    .i_rIdx (w_index),
    .o_rTag (w_lineTag),
    .o_rDat (w_lineDat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IC_IDLE;
      r_drop   <= 1'b0;
      r_valid  <= '0;
      r_insEn  <= 1'b0;
      r_ins    <= '0;
      r_mcEn   <= 1'b0;
      r_mcAddr <= '0;
    end else if (en) begin
      case (r_state)
        IC_IDLE: begin
          r_insEn <= 1'b0;
          if (iIF_En && !iClr) begin
            if (w_hit) begin
              r_ins   <= w_lineDat;
              r_insEn <= 1'b1;
            end else begin
              r_state  <= IC_MISS;
              r_mcEn   <= 1'b1;
              r_mcAddr <= iIF_Pc & ~ADDR_W'(3);
              r_drop   <= 1'b0;
            end
          end
        end
        IC_MISS: begin
          r_insEn <= 1'b0;
          if (iMC_En) begin
            r_valid[w_fillIdx] <= 1'b1;
            r_ins              <= iMC_Dat;
            r_insEn            <= !(r_drop || iClr);
            r_mcEn             <= 1'b0;
            r_state            <= IC_IDLE;
          end else if (iClr) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

  assign oIns_En  = r_insEn;
  assign oIns     = r_ins;
  assign oMC_En   = r_mcEn;
  assign oMC_Addr = r_mcAddr;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: transaction-level cache model checked every
// cycle, plus literal expectations at the interesting points.
module tb_icache;
  import icache_pkg::*;

  localparam int LINES = 1 << ICACHE_INDEX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        iIF_En = 1'b0;
  logic [31:0] iIF_Pc = '0;
  logic        oIF_Rdy;
  logic        iClr = 1'b0;
  logic        oIns_En;
  logic [31:0] oIns;
  logic        oMC_En;
  logic [31:0] oMC_Addr;
  logic        iMC_En = 1'b0;
  logic [31:0] iMC_Dat = '0;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .iIF_En   (iIF_En),
    .iIF_Pc   (iIF_Pc),
    .oIF_Rdy  (oIF_Rdy),
    .iClr     (iClr),
    .oIns_En  (oIns_En),
    .oIns     (oIns),
    .oMC_En   (oMC_En),
    .oMC_Addr (oMC_Addr),
    .iMC_En   (iMC_En),
    .iMC_Dat  (iMC_Dat)
  );

  always #5 clk = ~clk;

  // Cache model: each resident line remembers the full word address it holds.
  logic [29:0] mLineWord [int];
  logic [31:0] mLineDat  [int];
  bit          mBusy = 0;
  bit          mDropped = 0;
  logic [31:0] mPendAddr = '0;
  logic        eInsEn = 0;
  logic [31:0] eIns = '0;

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      mLineWord.delete();
      mLineDat.delete();
      mBusy = 0;
      mDropped = 0;
      mPendAddr = '0;
      eInsEn = 0;
      eIns = '0;
    end else if (en) begin
      eInsEn = 0;
      if (!mBusy) begin
        if (iIF_En && !iClr) begin
          idx = int'((iIF_Pc >> 2) % LINES);
          if (mLineWord.exists(idx) && mLineWord[idx] == iIF_Pc[31:2]) begin
            eIns = mLineDat[idx];
            eInsEn = 1;
          end else begin
            mBusy = 1;
            mDropped = 0;
            mPendAddr = {iIF_Pc[31:2], 2'b00};
          end
        end
      end else if (iMC_En) begin
        idx = int'((mPendAddr >> 2) % LINES);
        mLineWord[idx] = mPendAddr[31:2];
        mLineDat[idx] = iMC_Dat;
        eIns = iMC_Dat;
        eInsEn = !(mDropped || iClr);
        mBusy = 0;
      end else if (iClr) begin
        mDropped = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("rdy", {31'b0, oIF_Rdy}, {31'b0, !mBusy});
      checkOutput("insEn", {31'b0, oIns_En}, {31'b0, eInsEn});
      checkOutput("ins", oIns, eIns);
      checkOutput("mcEn", {31'b0, oMC_En}, {31'b0, mBusy});
      checkOutput("mcAddr", oMC_Addr, mPendAddr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic e, input logic f, input logic [31:0] pc,
                               input logic c, input logic m, input logic [31:0] d);
    en = e;
    iIF_En = f;
    iIF_Pc = pc;
    iClr = c;
    iMC_En = m;
    iMC_Dat = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
  endtask

  // Miss on pc, wait some cycles, return data and check delivery.
  task automatic missFill(input logic [31:0] pc, input logic [31:0] dat, input int waitCycles);
    applyStimulus(1, 1, pc, 0, 0, 32'h0);
    checkOutput("missMcEn", {31'b0, oMC_En}, 32'd1);
    checkOutput("missAddr", oMC_Addr, pc & 32'hFFFF_FFFC);
    idle(waitCycles);
    applyStimulus(1, 0, 32'h0, 0, 1, dat);
    checkOutput("fillInsEn", {31'b0, oIns_En}, 32'd1);
    checkOutput("fillIns", oIns, dat);
    checkOutput("fillMcEnLow", {31'b0, oMC_En}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    started = 1;
    checkOutput("rstInsEn", {31'b0, oIns_En}, 32'd0);
    checkOutput("rstIns", oIns, 32'h0);
    checkOutput("rstMcEn", {31'b0, oMC_En}, 32'd0);
    checkOutput("rstRdy", {31'b0, oIF_Rdy}, 32'd1);

    // First miss on 0x0, data five cycles after the request edge.
    missFill(32'h0, 32'h0000_0013, 4);

    // Re-request hits one cycle later without touching memory.
    applyStimulus(1, 1, 32'h0, 0, 0, 32'h0);
    checkOutput("hit0En", {31'b0, oIns_En}, 32'd1);
    checkOutput("hit0Ins", oIns, 32'h0000_0013);
    checkOutput("hit0McEn", {31'b0, oMC_En}, 32'd0);

    missFill(32'h4, 32'h1111_0004, 1);
    missFill(32'hB, 32'h2222_0008, 0);

    // Back-to-back hits in order; low pc bits ignored.
    applyStimulus(1, 1, 32'h0, 0, 0, 32'h0);
    checkOutput("b2b0", oIns, 32'h0000_0013);
    applyStimulus(1, 1, 32'h5, 0, 0, 32'h0);
    checkOutput("b2b1", oIns, 32'h1111_0004);
    applyStimulus(1, 1, 32'h8, 0, 0, 32'h0);
    checkOutput("b2b2", oIns, 32'h2222_0008);
    checkOutput("b2bEn", {31'b0, oIns_En}, 32'd1);
    idle(1);
    checkOutput("b2bEnd", {31'b0, oIns_En}, 32'd0);

    // Conflict on index 0: 0x400 replaces 0x0, then 0x0 misses again.
    missFill(32'h400, 32'hDEAD_0400, 2);
    applyStimulus(1, 1, 32'h400, 0, 0, 32'h0);
    checkOutput("hit400", oIns, 32'hDEAD_0400);
    missFill(32'h0, 32'h0000_0013, 1);

    // Flush two cycles into a miss: no delivery, but the line fills.
    applyStimulus(1, 1, 32'h10, 0, 0, 32'h0);
    idle(1);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    idle(1);
    applyStimulus(1, 0, 32'h0, 0, 1, 32'hC0DE_0010);
    checkOutput("clrNoDeliver", {31'b0, oIns_En}, 32'd0);
    checkOutput("clrRdy", {31'b0, oIF_Rdy}, 32'd1);
    applyStimulus(1, 1, 32'h10, 0, 0, 32'h0);
    checkOutput("clrHitEn", {31'b0, oIns_En}, 32'd1);
    checkOutput("clrHitIns", oIns, 32'hC0DE_0010);

    // Flush in the same cycle as the fill.
    applyStimulus(1, 1, 32'h14, 0, 0, 32'h0);
    idle(2);
    applyStimulus(1, 0, 32'h0, 1, 1, 32'hC0DE_0014);
    checkOutput("clrFillEn", {31'b0, oIns_En}, 32'd0);
    applyStimulus(1, 1, 32'h14, 0, 0, 32'h0);
    checkOutput("clrFillHit", oIns, 32'hC0DE_0014);

    // Flush in idle drops the request without a lookup side effect.
    applyStimulus(1, 1, 32'h40, 1, 0, 32'h0);
    checkOutput("idleClrEn", {31'b0, oIns_En}, 32'd0);
    checkOutput("idleClrMc", {31'b0, oMC_En}, 32'd0);

    // Reset mid-miss, late memory response ignored, cache emptied.
    applyStimulus(1, 1, 32'h20, 0, 0, 32'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("rstMissMc", {31'b0, oMC_En}, 32'd0);
    checkOutput("rstMissRdy", {31'b0, oIF_Rdy}, 32'd1);
    applyStimulus(1, 0, 32'h0, 0, 1, 32'hBAD0_0020);
    checkOutput("lateMcEn", {31'b0, oIns_En}, 32'd0);
    applyStimulus(1, 1, 32'h0, 0, 0, 32'h0);
    checkOutput("postRstMiss", {31'b0, oMC_En}, 32'd1);
    idle(1);

    // Freeze for three cycles mid-miss, with flush and requests ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h44, 1, 0, 32'h0);
      checkOutput("frzMcEn", {31'b0, oMC_En}, 32'd1);
      checkOutput("frzAddr", oMC_Addr, 32'h0);
      checkOutput("frzRdy", {31'b0, oIF_Rdy}, 32'd0);
    end
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h0000_0077);
    checkOutput("frzDone", {31'b0, oIns_En}, 32'd1);
    checkOutput("frzIns", oIns, 32'h0000_0077);
    idle(2);

    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. It accepts one fetch PC at a time and returns the 32-bit instruction word. The response strobe (`oIns_En`/`oIns`) drives the branch predictor's `iIC_En`/`iIC_Ins` and the fetch stage. Misses issue a single word read to the memory controller and fill the line on return.

## Interface
- `INDEX_W`, 8: index bits; the cache has 2^INDEX_W lines of one instruction each.
- `ADDR_W`, 32 (`REG_DAT_W`): address width.
- `INS_W`, 32 (`INS_DAT_W`): instruction width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  global ready; when low, every register holds its value.
- `iIF_En`  in  1  fetch request valid; sampled only when `oIF_Rdy`=1.
- `iIF_Pc`  in  ADDR_W  fetch address; bits [1:0] are ignored.
- `oIF_Rdy`  out  1  combinational; high when state=IDLE.
- `iClr`  in  1  discard any pending or in-flight response (mispredict flush).
- `oIns_En`  out  1  registered one-cycle response strobe (to IF and BP).
- `oIns`  out  INS_W  instruction; holds the last delivered value between strobes.
- `oMC_En`  out  1  memory read request; held until acknowledged.
- `oMC_Addr`  out  ADDR_W  word-aligned read address.
- `iMC_En`  in  1  one-cycle read-done pulse.
- `iMC_Dat`  in  INS_W  read data, valid with `iMC_En`.

## Operation
- Address split:
  - index = pc[INDEX_W+1:2];
  - tag = pc[ADDR_W-1:INDEX_W+2];
  - each line stores a valid bit, the tag and the data word.
- Hit = valid[index] && tag match. Lookup is combinational on `iIF_Pc`.
- States: IDLE and MISS. A `drop` flag accompanies MISS.
- IDLE with `iIF_En`=1 and `iClr`=0:
  - On a hit: at the edge, `oIns`<=data and `oIns_En`<=1. The state stays IDLE.
  - On a miss: at the edge, state<=MISS, `oMC_En`<=1, `oMC_Addr`<={pc[ADDR_W-1:2],2'b00}, drop<=0.
- IDLE with no accepted request: `oIns_En`<=0.
- MISS:
  - `oMC_En` and `oMC_Addr` are held stable.
  - New requests are ignored, because `oIF_Rdy`=0.
  - `iClr`=1 sets drop<=1.
- MISS with `iMC_En`=1:
  - write the line (valid=1, tag, `iMC_Dat`);
  - `oIns`<=`iMC_Dat`;
  - `oIns_En`<=!(drop||`iClr`);
  - `oMC_En`<=0;
  - state<=IDLE.
- `iClr` in IDLE:
  - forces `oIns_En`<=0;
  - the same-cycle request is dropped;
  - the cache contents are untouched.
- The memory transaction is never aborted. A flushed miss still fills its line.
- Conflict: a fill overwrites the line unconditionally. There is no replacement policy.
- `en`=0 freezes state, outputs and arrays. The memory controller shares `en`, so `iMC_En` is never high while `en`=0.

## Timing
- Reset values:
  - state IDLE, all valid bits 0, drop 0;
  - `oIns_En`=0, `oIns`=0, `oMC_En`=0, `oMC_Addr`=0.
- Reset during MISS returns to IDLE the next cycle. Any later `iMC_En` is ignored in IDLE.
- Hit latency: a request sampled at edge N gives `oIns_En`=1 in cycle N+1. Back-to-back hits give one response per cycle.
- Miss latency:
  - `oMC_En` rises in cycle N+1;
  - `iMC_En` sampled at edge M gives `oIns_En` in cycle M+1;
  - `oIF_Rdy` is high again in cycle M+1, so a new request can be sampled at the edge closing cycle M+1.
- `iClr` together with `iMC_En` at the same edge: the line fills and there is no delivery.
- `rst` has priority over `en`; `en` has priority over all other inputs.

## Structure
- `header.vh` gains:
  - `ICACHE_INDEX_W`;
  - state encodings `IC_IDLE`/`IC_MISS`.
- `INS_DAT_W` and `REG_DAT_W` are reused.
- One sub-module, `icache_line_ram`:
  - data and tag arrays;
  - combinational read port;
  - synchronous write port.
- The valid vector stays in `icache` so that reset clears it in one cycle.

## Test plan
- Reset, then request pc 0x0 → `oMC_En`=1 with `oMC_Addr`=0x0 next cycle. Memory controller returns 0x00000013 five cycles later → `oIns_En` pulse with `oIns`=0x00000013, and `oMC_En`=0.
- Re-request 0x0 → `oIns_En` at N+1 with 0x00000013; `oMC_En` stays 0.
- Hits at 0x0, 0x4, 0x8 on consecutive cycles, all pre-filled → three consecutive `oIns_En` pulses in order.
- Conflict, with INDEX_W=8:
  - fill 0x0, then request 0x400 → miss, and the line is replaced;
  - request 0x0 again → miss.
- Assert `iClr` two cycles into a miss on 0x10 → no `oIns_En` on completion. A following request to 0x10 hits.
- `rst` during a miss:
  - `oMC_En`=0 and `oIF_Rdy`=1 next cycle;
  - a late `iMC_En` is ignored;
  - request 0x0 misses.
- `en`=0 for 3 cycles mid-miss → outputs frozen; completion proceeds after `en` returns.
